// File: rtl/mem_load_unit_if.sv
// Load-unit bundle: issue-side request, data-memory read port, ROB/CDB writeback.
// The unit itself takes the slave view; the environment drives through the master view.
interface mem_load_unit_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2,
    parameter int TAG_W  = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [TAG_W-1:0]  in_tag;
    logic [ADDR_W-1:0] in_addr;
    logic              squash;
    logic [ADDR_W-1:0] memd_req_addr;
    logic [DATA_W-1:0] memd_resp_data;
    logic              wb_valid;
    logic              wb_ready;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              busy;

    modport slave (
        input  in_valid, in_tag, in_addr, squash, memd_resp_data, wb_ready,
        output in_ready, memd_req_addr, wb_valid, wb_tag, wb_data, busy
    );

    modport master (
        output in_valid, in_tag, in_addr, squash, memd_resp_data, wb_ready,
        input  in_ready, memd_req_addr, wb_valid, wb_tag, wb_data, busy
    );
endinterface

// File: rtl/mem_load_unit.sv
// In-order load unit: request FIFO, fixed-latency access to a combinational data
// memory, and a valid/ready writeback of the tagged result. squash flushes everything.
module mem_load_unit #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2,
    parameter int TAG_W  = 2,
    parameter int DEPTH  = 4,
    parameter int LAT    = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_load_unit_if.slave  io_lsu
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [PTR_W:0]    r_count;
    logic [CNT_W-1:0]  r_lat_cnt;
    logic [TAG_W-1:0]  r_wb_tag;
    logic [DATA_W-1:0] r_wb_data;
    logic [TAG_W-1:0]  r_tag_mem  [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // in_ready deliberately ignores a same-cycle pop: no full-FIFO bypass.
    assign w_push  = io_lsu.in_valid && io_lsu.in_ready;
    assign w_pop   = (r_state == S_RESP) && io_lsu.wb_ready;

    assign io_lsu.in_ready      = !w_full && !io_lsu.squash;
    assign io_lsu.memd_req_addr = w_empty ? '0 : r_addr_mem[r_head];
    assign io_lsu.wb_valid      = (r_state == S_RESP);
    assign io_lsu.wb_tag        = r_wb_tag;
    assign io_lsu.wb_data       = r_wb_data;
    assign io_lsu.busy          = !w_empty || (r_state != S_IDLE);

    // FIFO payload storage; pointers and count live with the control state below.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_tail]  <= io_lsu.in_tag;
            r_addr_mem[r_tail] <= io_lsu.in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || io_lsu.squash) begin
            r_state   <= S_IDLE;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_lat_cnt <= '0;
            r_wb_tag  <= '0;
            r_wb_data <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_lat_cnt <= LAT_INIT;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt != '0) begin
                        r_lat_cnt <= r_lat_cnt - CNT_W'(1);
                    end else begin
                        r_wb_data <= io_lsu.memd_resp_data;
                        r_wb_tag  <= r_tag_mem[r_head];
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (io_lsu.wb_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_load_unit.sv
// Random-stimulus bench for mem_load_unit: a LAT=2 and a LAT=1 instance share every
// input and are each compared cycle by cycle against a queue-based reference model.
module tb_mem_load_unit;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 2;
    localparam int TAG_W  = 2;
    localparam int DEPTH  = 4;
    localparam int NCYC   = 4000;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
    } req_t;

    logic clk = 1'b1;
    logic rst;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    mem_load_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus0 ();
    mem_load_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus1 ();

    assign bus0.memd_resp_data = mem[bus0.memd_req_addr];
    assign bus1.memd_resp_data = mem[bus1.memd_req_addr];

    mem_load_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .LAT(2))
        u_dut_lat2 (.clk(clk), .rst(rst), .io_lsu(bus0.slave));
    mem_load_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH), .LAT(1))
        u_dut_lat1 (.clk(clk), .rst(rst), .io_lsu(bus1.slave));

    // Reference model: pending loads, cycles left before the result is presented
    // (-1 = not servicing), and whether the result is currently on offer.
    req_t              mq [2][$];
    int                timer  [2];
    bit                resp   [2];
    logic [TAG_W-1:0]  m_tag  [2];
    logic [DATA_W-1:0] m_data [2];
    int                latv   [2];

    int n_chk  = 0;
    int n_pass = 0;

    logic              rst_v, sq_v, iv_v, wr_v;
    logic [TAG_W-1:0]  tag_v;
    logic [ADDR_W-1:0] addr_v;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_unit(input int d, input logic wv, input logic [TAG_W-1:0] wt,
                              input logic [DATA_W-1:0] wd, input logic bz,
                              input logic [ADDR_W-1:0] ra);
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = (mq[d].size() != 0) ? mq[d][0].addr : '0;
        chk($sformatf("wb_valid[%0d]", d), 32'(wv), 32'(resp[d]));
        chk($sformatf("wb_tag[%0d]", d), 32'(wt), 32'(m_tag[d]));
        chk($sformatf("wb_data[%0d]", d), 32'(wd), 32'(m_data[d]));
        chk($sformatf("busy[%0d]", d), 32'(bz),
            32'(mq[d].size() != 0 || timer[d] != -1 || resp[d]));
        chk($sformatf("req_addr[%0d]", d), 32'(ra), 32'(exp_addr));
    endtask

    task automatic model_step(input int d);
        req_t r;
        bit   push;
        push   = iv_v && !sq_v && (mq[d].size() < DEPTH);
        r.tag  = tag_v;
        r.addr = addr_v;
        if (rst_v || sq_v) begin
            mq[d].delete();
            timer[d]  = -1;
            resp[d]   = 1'b0;
            m_tag[d]  = '0;
            m_data[d] = '0;
        end else begin
            if (resp[d]) begin
                if (wr_v) begin
                    void'(mq[d].pop_front());
                    resp[d] = 1'b0;
                end
            end else if (timer[d] > 0) begin
                timer[d]--;
                if (timer[d] == 0) begin
                    timer[d]  = -1;
                    resp[d]   = 1'b1;
                    m_tag[d]  = mq[d][0].tag;
                    m_data[d] = mem[mq[d][0].addr];
                end
            end else if (mq[d].size() != 0) begin
                // One cycle to notice the head, then LAT cycles of access.
                timer[d] = latv[d];
            end
            if (push) mq[d].push_back(r);
        end
    endtask

    initial begin
        int phase;
        latv[0] = 2;
        latv[1] = 1;
        for (int d = 0; d < 2; d++) begin
            timer[d]  = -1;
            resp[d]   = 1'b0;
            m_tag[d]  = '0;
            m_data[d] = '0;
        end
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
        rst = 1'b1;
        {bus0.in_valid, bus0.squash, bus0.wb_ready} = '0;
        {bus1.in_valid, bus1.squash, bus1.wb_ready} = '0;
        bus0.in_tag = '0; bus0.in_addr = '0;
        bus1.in_tag = '0; bus1.in_addr = '0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                check_unit(0, bus0.wb_valid, bus0.wb_tag, bus0.wb_data, bus0.busy, bus0.memd_req_addr);
                check_unit(1, bus1.wb_valid, bus1.wb_tag, bus1.wb_data, bus1.busy, bus1.memd_req_addr);
            end

            phase  = (cyc / 400) % 4;
            rst_v  = (cyc < 2) || ($urandom_range(0, 249) == 0);
            sq_v   = (phase != 2) && ($urandom_range(0, 79) == 0);
            tag_v  = TAG_W'($urandom);
            addr_v = ADDR_W'($urandom);
            case (phase)
                0:       begin iv_v = ($urandom_range(0, 9) < 4); wr_v = ($urandom_range(0, 9) < 9); end
                1:       begin iv_v = ($urandom_range(0, 9) < 7); wr_v = ($urandom_range(0, 19) == 0); end
                2:       begin iv_v = 1'b1; wr_v = 1'b1; end
                default: begin iv_v = $urandom_range(0, 1) != 0; wr_v = $urandom_range(0, 1) != 0; end
            endcase
            if (cyc % 50 == 0) mem[$urandom_range(0, 2**ADDR_W - 1)] = DATA_W'($urandom);

            rst = rst_v;
            bus0.squash = sq_v;  bus1.squash = sq_v;
            bus0.in_valid = iv_v; bus1.in_valid = iv_v;
            bus0.in_tag = tag_v;  bus1.in_tag = tag_v;
            bus0.in_addr = addr_v; bus1.in_addr = addr_v;
            bus0.wb_ready = wr_v; bus1.wb_ready = wr_v;
            #1;
            if (cyc > 0) begin
                chk("in_ready[0]", 32'(bus0.in_ready), 32'(!sq_v && mq[0].size() < DEPTH));
                chk("in_ready[1]", 32'(bus1.in_ready), 32'(!sq_v && mq[1].size() < DEPTH));
            end
            model_step(0);
            model_step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
